// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide sequencer for the Execute
//               stage. Radix-2 shift-add multiply and restoring divide, one
//               iteration per cycle, with sign correction, RISC-V divide
//               special cases and the isMulE/isDone stall handshake.
//               Optional macro MULDIV_FAST_ZERO_EN: trivial operations
//               (divide by zero, signed overflow, multiply by zero) go
//               straight from IDLE to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] C_OP_MUL    = 3'd0;
    localparam logic [2:0] C_OP_MULH   = 3'd1;
    localparam logic [2:0] C_OP_MULHSU = 3'd2;
    localparam logic [2:0] C_OP_DIV    = 3'd4;
    localparam logic [2:0] C_OP_REM    = 3'd6;

    localparam logic [W-1:0] C_INT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q,    state_d;
    logic [2:0]             op_q,       op_d;
    logic [2*W-1:0]         acc_q,      acc_d;      // {hi,multiplier} or {rem,quot}
    logic [W-1:0]           dvs_q,      dvs_d;      // multiplicand or divisor magnitude
    logic                   qneg_q,     qneg_d;     // negate product / quotient
    logic                   rneg_q,     rneg_d;     // negate remainder
    logic                   spec_q,     spec_d;     // special-case override pending
    logic [W-1:0]           spec_val_q, spec_val_d;
    logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
    logic [W-1:0]           result_q,   result_d;

    // Operand decode at start: signedness, magnitudes and special cases
    logic           w_is_div;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic           w_b_zero;
    logic           w_ovf;
    logic           w_spec;
    logic [W-1:0]   w_spec_val;
    logic           w_fast;

    always_comb begin
        w_is_div   = op_i[2];
        w_a_neg    = a_i[W-1] & ((op_i == C_OP_MULH) | (op_i == C_OP_MULHSU) |
                                 (op_i == C_OP_DIV)  | (op_i == C_OP_REM));
        w_b_neg    = b_i[W-1] & ((op_i == C_OP_MULH) | (op_i == C_OP_DIV) |
                                 (op_i == C_OP_REM));
        w_a_mag    = w_a_neg ? -a_i : a_i;
        w_b_mag    = w_b_neg ? -b_i : b_i;
        w_b_zero   = (b_i == '0);
        w_ovf      = ((op_i == C_OP_DIV) | (op_i == C_OP_REM)) &
                     (a_i == C_INT_MIN) & (b_i == '1);
        w_spec     = w_is_div & (w_b_zero | w_ovf);
        // op_i[1] separates REM/REMU from DIV/DIVU; MUL-class defaults to zero
        w_spec_val = '0;
        if (w_is_div && w_b_zero) begin
            w_spec_val = op_i[1] ? a_i : '1;
        end else if (w_is_div && w_ovf) begin
            w_spec_val = op_i[1] ? '0 : C_INT_MIN;
        end
`ifdef MULDIV_FAST_ZERO_EN
        w_fast     = w_spec | (~w_is_div & ((a_i == '0) | w_b_zero));
`else
        w_fast     = 1'b0;
`endif
    end

    // One iteration of shift-add multiply or restoring divide, plus final result
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_rem_sub;
    logic           w_ge;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_step;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_final;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[W-1:1]};
        // Shifted remainder needs W+1 bits so a divisor >= 2^(W-1) compares correctly
        w_rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        w_ge       = (w_rem_sh >= {1'b0, dvs_q});
        w_rem_sub  = w_rem_sh - {1'b0, dvs_q};
        w_div_next = {(w_ge ? w_rem_sub[W-1:0] : w_rem_sh[W-1:0]), acc_q[W-2:0], w_ge};
        w_step     = op_q[2] ? w_div_next : w_mul_next;

        w_prod     = qneg_q ? -w_step : w_step;
        w_quot     = qneg_q ? -w_step[W-1:0] : w_step[W-1:0];
        w_rem      = rneg_q ? -w_step[2*W-1:W] : w_step[2*W-1:W];

        w_final    = '0;
        case (op_q)
            C_OP_MUL:              w_final = w_prod[W-1:0];
            3'd1, 3'd2, 3'd3:      w_final = w_prod[2*W-1:W];
            3'd4, 3'd5:            w_final = w_quot;
            default:               w_final = w_rem;
        endcase
        if (spec_q) begin
            w_final = spec_val_q;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        cnt_d      = cnt_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d       = op_i;
                    qneg_d     = w_a_neg ^ w_b_neg;
                    rneg_d     = w_a_neg;
                    spec_d     = w_spec;
                    spec_val_d = w_spec_val;
                    if (w_fast) begin
                        state_d  = ST_DONE;
                        result_d = w_spec_val;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_WIDTH'(DATA_WIDTH);
                        acc_d   = {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        dvs_d   = w_is_div ? w_b_mag : w_a_mag;
                    end
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d  = ST_DONE;
                        result_d = w_final;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            dvs_q      <= dvs_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer: directed RV32M
//               cases, randomized operations against a behavioural model,
//               flush, start-with-flush and asynchronous reset scenarios.
//               Honours MULDIV_FAST_ZERO_EN for the expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [2:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          flush_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_res = '0;

    muldiv_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
                eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
                p  = ea * eb;
                return (op == 3'd0) ? p[31:0] : p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_FAST_ZERO_EN
        if (op[2])
            return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one op with start held through DONE, scramble operands while busy
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int busy_n   = 0;
        int lat      = 0;
        int held_bad = 0;
        bit fast;
        fast = is_fast(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            a_i = $urandom; b_i = $urandom; op_i = 3'($urandom_range(0, 7));
            if (done_o) begin
                lat = k;
                break;
            end
            if (busy_o) busy_n++;
            if (result_o !== last_res) held_bad++;
        end
        check({tag, " latency"}, lat, fast ? 1 : W + 1);
        check({tag, " busy"}, busy_n, fast ? 0 : W);
        check({tag, " held"}, held_bad, 0);
        check({tag, " result"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, " done drop"}, {busy_o, done_o}, 0);
        check({tag, " result keep"}, result_o, exp);
        last_res = exp;
    endtask

    initial begin
        int dn;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {busy_o, done_o}, 0);
        check("reset result", result_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {busy_o, done_o}, 0);

        // Directed cases with literal expectations
        run_op("MUL 7x-3",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("MULH min*min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_op("MULHU max*max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("MULHSU -1*max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("REM -7%2",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("DIVU 100/7",     3'd5, 32'd100,        32'd7,         32'd14);
        run_op("REMU 100%7",     3'd7, 32'd100,        32'd7,         32'd2);
        run_op("DIVU 5/0",       3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("REM 5%0",        3'd6, 32'd5,          32'd0,         32'd5);
        run_op("DIV -5/0",       3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF);
        run_op("REM -5%0",       3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
        run_op("DIV ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("REM ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run_op("MUL 0x5",        3'd0, 32'd0,          32'd5,         32'd0);

        // Randomized ops against the model, biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = '0;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op("random", op, a, b, ref_result(op, a, b));
        end

        // Flush at iteration 10: back to IDLE, no done, result kept
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3;
        repeat (10) @(negedge clk);
        check("flush busy before", busy_o, 1);
        start_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush idle", {busy_o, done_o}, 0);
        check("flush result kept", result_o, last_res);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || busy_o) dn++;
        end
        check("flush no done", dn, 0);
        run_op("after flush", 3'd5, 32'd1000, 32'd3, 32'd333);

        // Start together with flush in IDLE is not accepted
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; a_i = 32'd9; b_i = 32'd0;
        @(negedge clk);
        check("start+flush ignored", {busy_o, done_o}, 0);
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("start+flush still idle", {busy_o, done_o}, 0);
        check("start+flush result", result_o, last_res);

        // Asynchronous reset between edges in the middle of RUN
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; a_i = 32'd12345; b_i = 32'd678;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst flags", {busy_o, done_o}, 0);
        check("async rst result", result_o, 0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        last_res = '0;
        run_op("after rst", 3'd0, 32'd12345, 32'd678, 32'd8369910);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
